// File: rtl/dmem_responder.sv
// Single-port data memory slave with valid/ready request and response channels.
// Each request waits LATENCY cycles, then the access and the response happen together.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
  } req_t;

  state_e      state_q;
  logic [3:0]  cnt_q;
  req_t        req_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // Zero power-up contents for simulation; rst deliberately leaves storage alone.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  req_t             live;
  req_t             acc;
  logic             accept;
  logic             commit;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      wdata_rep;
  logic [31:0]      wr_word;
  logic [31:0]      load_val;
  logic [31:0]      resp_rdata_d;
  logic [7:0]       sel8;
  logic [15:0]      sel16;
  logic [3:0]       byte_en;
  logic             acc_err;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign live      = {req_write, req_addr, req_wdata, req_size, req_signed};

  // With LATENCY=0 the access happens on the acceptance edge, so it must see the live request.
  assign acc     = (state_q == IDLE) ? live : req_q;
  assign idx     = acc.addr[IDX_W+1:2];
  assign rd_word = mem_q[idx];
  assign commit  = ((state_q == IDLE) && accept && (LATENCY == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    acc_err   = 1'b0;
    byte_en   = 4'b0000;
    wdata_rep = acc.wdata;
    load_val  = rd_word;
    sel8      = 8'(rd_word >> {acc.addr[1:0], 3'b000});
    sel16     = acc.addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc.size)
      2'b00: begin
        byte_en   = 4'b0001 << acc.addr[1:0];
        wdata_rep = {4{acc.wdata[7:0]}};
        load_val  = {{24{acc.sgn & sel8[7]}}, sel8};
      end
      2'b01: begin
        acc_err   = acc.addr[0];
        byte_en   = acc.addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{acc.wdata[15:0]}};
        load_val  = {{16{acc.sgn & sel16[15]}}, sel16};
      end
      2'b10: begin
        acc_err = |acc.addr[1:0];
        byte_en = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
    if ({1'b0, acc.addr} >= BYTE_LIMIT) acc_err = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = byte_en[b] ? wdata_rep[8*b +: 8] : rd_word[8*b +: 8];
    end
    resp_rdata_d = (acc_err || acc.write) ? 32'd0 : load_val;
  end

  // NOTE: the memory array has no reset branch; clearing it would need a write port per word.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc.write && !acc_err) mem_q[idx] <= wr_word;
  end

  // NOTE: all sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q <= live;
            if (LATENCY == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= resp_rdata_d;
              resp_err_q   <= acc_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= acc_err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 (index 0) and one with LATENCY=0 (index 1),
// checked against a byte-array model of memory and the access rules.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [7:0] model [2][1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Expected outcome from the access rules, reading memory as little-endian bytes.
  task automatic model_eval(input int d, input logic wr, input logic [31:0] addr,
                            input logic [1:0] size, input logic sgn,
                            output logic [31:0] rd, output logic err);
    int nb;
    logic [31:0] ext;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr % nb) != 0) || (addr >= 32'd1024);
    rd  = 32'd0;
    if (!err && !wr) begin
      for (int i = 0; i < nb; i++) rd = rd | (32'(model[d][addr + i]) << (8 * i));
      if (sgn && nb < 4 && rd[8*nb-1]) begin
        ext = 32'hFFFF_FFFF;
        rd  = rd | (ext << (8 * nb));
      end
    end
  endtask

  task automatic model_store(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size);
    int nb;
    logic [31:0] tmp;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) begin
      tmp = wdata >> (8 * i);
      model[d][addr + i] = tmp[7:0];
    end
  endtask

  // One request/response handshake, with resp_ready held low for `hold` cycles of RESP.
  task automatic txn(input int d, input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                     input int hold, output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] exp_rdata;
    logic exp_err;
    int lat, w;
    model_eval(d, wr, addr, size, sgn, exp_rdata, exp_err);
    @(negedge clk);
    w = 0;
    while (!req_ready[d] && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++; $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wdata; req_size[d] = size; req_signed[d] = sgn;
    resp_ready[d] = (hold == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_size[d] = 2'($urandom); req_signed[d] = 1'($urandom);
    @(negedge clk);
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat != lat_of(d)) begin
      errors++; $display("FAIL %s latency: got %0d cycles required %0d", name, lat, lat_of(d));
    end
    got_rdata = resp_rdata[d];
    got_err   = resp_err[d];
    checks++;
    if (got_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h required %h", name, got_rdata, exp_rdata);
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++; $display("FAIL %s err: got %b required %b", name, got_err, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== got_rdata || resp_err[d] !== got_err ||
          req_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                 name, i, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d],
                 got_rdata, got_err);
      end
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s to_idle: valid=%b ready=%b required 0 1", name, resp_valid[d], req_ready[d]);
    end
    resp_ready[d] = 1'b0;
    if (!exp_err && wr) model_store(d, addr, wdata, size);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) rst[d] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 ||
          resp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: ready=%b valid=%b rdata=%h err=%b required all zero",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
      rst[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_release[%0d]: req_ready=%b required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_directed_l2();
    logic [31:0] r;
    logic e;
    txn(0, "st_word", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, r, e);
    txn(0, "ld_word", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_word_const: got %h required deadbeef", r); end
    txn(0, "st_byte", 1'b1, 32'h13, 32'h80, 2'd0, 1'b0, 0, r, e);
    txn(0, "ld_sbyte", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, r, e);
    checks++;
    if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL ld_sbyte_const: got %h required ffffff80", r); end
    txn(0, "ld_ubyte", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, r, e);
    checks++;
    if (r !== 32'h0000_0080) begin errors++; $display("FAIL ld_ubyte_const: got %h required 00000080", r); end
    txn(0, "ld_merged", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (r !== 32'h80AD_BEEF) begin errors++; $display("FAIL ld_merged_const: got %h required 80adbeef", r); end
    txn(0, "ld_half_mis", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0, r, e);
    checks++;
    if (e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL half_mis_const: got err=%b rdata=%h required 1 0", e, r); end
    txn(0, "ld_word_mis", 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL word_mis_const: got err=%b rdata=%h required 1 0", e, r); end
    txn(0, "st_oor", 1'b1, 32'h400, 32'h5555_AAAA, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL st_oor_const: got err=%b required 1", e); end
    txn(0, "ld_alias0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL ld_alias0_const: got %h required 00000000", r); end
    txn(0, "ld_hold5", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, r, e);
  endtask

  task automatic test_reset_abandon();
    logic [31:0] r;
    logic e;
    int w;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h1234_5678; req_size[0] = 2'd2; resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_wait_valid%0d: got %b required 0", i, resp_valid[0]); end
    end
    rst[0] = 1'b0;
    resp_ready[0] = 1'b0;
    txn(0, "ld_after_rst", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL ld_after_rst_const: got %h required 00000000", r); end
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = 2'd2;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    w = 0;
    while (!resp_valid[0] && w < 20) begin @(negedge clk); w++; end
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp_discard: valid=%b rdata=%h ready=%b required 0 0 0",
               resp_valid[0], resp_rdata[0], req_ready[0]);
    end
    rst[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL rst_resp_idle: ready=%b valid=%b required 1 0", req_ready[0], resp_valid[0]);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] r;
    logic e;
    txn(1, "l0_st_word", 1'b1, 32'h40, 32'hCAFE_F00D, 2'd2, 1'b0, 0, r, e);
    txn(1, "l0_ld_word", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, r, e);
    checks++;
    if (r !== 32'hCAFE_F00D) begin errors++; $display("FAIL l0_ld_word_const: got %h required cafef00d", r); end
    txn(1, "l0_ld_shalf", 1'b0, 32'h42, 32'h0, 2'd1, 1'b1, 2, r, e);
    checks++;
    if (r !== 32'hFFFF_CAFE) begin errors++; $display("FAIL l0_ld_shalf_const: got %h required ffffcafe", r); end
  endtask

  task automatic test_back_to_back(input int d);
    int last, n_acc, w;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = 1'b0; req_addr[d] = 32'h10;
    req_size[d] = 2'd2; req_signed[d] = 1'b0; resp_ready[d] = 1'b1;
    last = -1; n_acc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (req_ready[d]) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != lat_of(d) + 2) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", d, cyc - last, lat_of(d) + 2);
          end
        end
        last = cyc; n_acc++;
      end
    end
    req_valid[d] = 1'b0;
    checks++;
    if (n_acc < 5) begin errors++; $display("FAIL b2b_count[%0d]: got %0d accepts required >=5", d, n_acc); end
    w = 0;
    while (!req_ready[d] && w < 20) begin @(negedge clk); w++; end
    resp_ready[d] = 1'b0;
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] r, addr;
    logic e;
    for (int i = 0; i < n; i++) begin
      addr = ($urandom_range(0, 9) == 0) ? 32'h3FC + $urandom_range(0, 8) : $urandom_range(0, 127);
      txn(d, "random", 1'($urandom), addr, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom), $urandom_range(0, 2), r, e);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_size[d] = 2'd0; req_signed[d] = 1'b0; resp_ready[d] = 1'b0;
      for (int a = 0; a < 1024; a++) model[d][a] = 8'd0;
    end
    test_reset();
    test_directed_l2();
    test_reset_abandon();
    test_latency0();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random(0, 60);
    test_random(1, 60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles inserted between request acceptance and memory access (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
REQ-010 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-011 SHALL have port req_signed  input  1  load sign-extends when 1 and zero-extends when 0.
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-014 SHALL have port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  request was rejected (misaligned, reserved size, out of range).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE with rst=0; a request is accepted on the edge where req_valid & req_ready.
REQ-018 SHALL register req_write, req_addr, req_wdata, req_size and req_signed on acceptance; later input changes have no effect on the accepted request.
REQ-019 On acceptance SHALL move to WAIT with a counter loaded to LATENCY, or directly to RESP when LATENCY=0.
REQ-020 In WAIT SHALL decrement the counter every cycle and enter RESP on the edge where the counter equals 1.
REQ-021 SHALL perform the memory access on the edge entering RESP: store bytes committed, load data captured, resp_err computed; resp_valid is first high in the cycle after edge N+LATENCY, where N is the acceptance edge.
REQ-022 In RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then return to IDLE on that edge with resp_valid=0.
REQ-023 SHALL NOT accept a new request during the cycle of the RESP→IDLE edge (no back-to-back overlap); maximum throughput is one request per LATENCY+2 cycles.
REQ-024 SHALL use little-endian byte order: byte lane = addr[1:0], half lane = addr[1].
REQ-025 A store SHALL update only the addressed byte lanes and leave the other lanes of the word unchanged.
REQ-026 A load SHALL extract the addressed lane and sign-extend it (req_signed=1) or zero-extend it (req_signed=0); a word load ignores req_signed.
REQ-027 SHALL flag an error for any of: half access with addr[0]=1, word access with addr[1:0]!=0, req_size=11, or addr >= 4*DEPTH_WORDS.
REQ-028 On error SHALL write no memory, set resp_rdata=0 and resp_err=1, and still complete the normal handshake timing.
REQ-029 SHALL set resp_err=0 and resp_rdata=0 for every successful store.

Reset
REQ-030 While rst=1 SHALL force state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0.
REQ-031 Reset asserted in WAIT or RESP SHALL abandon the request: a store not yet committed is never committed, and a pending response is discarded.
REQ-032 Storage contents SHALL NOT be cleared by rst; they initialise to zero at power-up for simulation.

Verification
REQ-033 LATENCY=2: word store 0xDEADBEEF to 0x10 accepted at edge N, resp_ready=1 → resp_valid high after edge N+2 with resp_err=0; word load from 0x10 → resp_rdata=0xDEADBEEF.
REQ-034 Byte store 0x80 to 0x13, then signed byte load from 0x13 → 0xFFFFFF80; unsigned byte load → 0x00000080; word load from 0x10 → 0x80ADBEEF.
REQ-035 Half load from 0x11 and word load from 0x12 → resp_err=1 and resp_rdata=0; word store to 0x400 with DEPTH_WORDS=256 → resp_err=1 and memory unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stay stable and req_ready=0; raise resp_ready → IDLE next cycle.
REQ-037 Store 0x12345678 to 0x20, assert rst in WAIT → no response, and a later load from 0x20 returns the prior value 0x00000000.
REQ-038 LATENCY=0: load accepted at edge N → resp_valid high after edge N; change req_addr after acceptance → response unaffected.
